// File: rtl/fifo_sync_param.sv
// fifo_sync_param: parametrised single-clock FIFO with simultaneous read/write,
// almost-full/almost-empty thresholds, occupancy output, sticky error flags and
// optional first-word-fall-through (FWFT) read mode.
//
// Ports:
//   Clk, Rst              clock, synchronous active-low reset
//   EN                    block enable (gates RD, WR, CLR_ERR)
//   WR, dataIn            write request and data
//   RD                    read request (standard) / pop acknowledge (FWFT)
//   CLR_ERR               clears OVERFLOW and UNDERFLOW (a coincident set wins)
//   dataOut, VALID        read data and its qualifier
//   EMPTY, FULL           Count == 0 / Count == DEPTH
//   ALMOST_EMPTY/FULL     Count <= AE_LEVEL / Count >= AF_LEVEL
//   Count                 occupancy 0..DEPTH
//   OVERFLOW, UNDERFLOW   sticky rejected-write / rejected-read flags
//
// Latency: standard mode 1 cycle from accepted RD to dataOut/VALID; FWFT mode
// shows the head word combinationally, one cycle after it is written.
// Backpressure: writes to a full FIFO are rejected unless a read is accepted in
// the same cycle; reads from an empty FIFO are rejected. Rejections set the
// sticky error flags and change no other state.
module fifo_sync_param #(
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 8,
  parameter int AF_LEVEL   = DEPTH - 2,
  parameter int AE_LEVEL   = 2,
  parameter int FWFT       = 0
) (
  input  logic                    Clk,
  input  logic                    Rst,
  input  logic                    EN,
  input  logic                    WR,
  input  logic [DATA_WIDTH-1:0]   dataIn,
  input  logic                    RD,
  input  logic                    CLR_ERR,
  output logic [DATA_WIDTH-1:0]   dataOut,
  output logic                    VALID,
  output logic                    EMPTY,
  output logic                    FULL,
  output logic                    ALMOST_EMPTY,
  output logic                    ALMOST_FULL,
  output logic [$clog2(DEPTH):0]  Count,
  output logic                    OVERFLOW,
  output logic                    UNDERFLOW
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];

  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          ovf_q, ovf_d;
  logic          unf_q, unf_d;

  logic          rd_acc;
  logic          wr_acc;
  logic [DATA_WIDTH-1:0] head_data;

  // A read accepted in the same cycle frees a slot, so a full FIFO still
  // accepts a write when it is also being read.
  assign rd_acc = EN && RD && (cnt_q != '0);
  assign wr_acc = EN && WR && ((cnt_q != DEPTH_C) || rd_acc);

  assign head_data = mem_q[rd_ptr_q];

  always_comb begin
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    cnt_d    = cnt_q;

    if (rd_acc) rd_ptr_d = rd_ptr_q + AW'(1);
    if (wr_acc) wr_ptr_d = wr_ptr_q + AW'(1);

    case ({wr_acc, rd_acc})
      2'b10:   cnt_d = cnt_q + CW'(1);
      2'b01:   cnt_d = cnt_q - CW'(1);
      default: cnt_d = cnt_q;
    endcase

    // Set takes priority over a coincident clear.
    ovf_d = (EN && WR && !wr_acc) || (ovf_q && !(EN && CLR_ERR));
    unf_d = (EN && RD && !rd_acc) || (unf_q && !(EN && CLR_ERR));
  end

  always_ff @(posedge Clk) begin
    if (!Rst) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      cnt_q    <= '0;
      ovf_q    <= 1'b0;
      unf_q    <= 1'b0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      cnt_q    <= cnt_d;
      ovf_q    <= ovf_d;
      unf_q    <= unf_d;
    end
  end

  // Storage is deliberately not reset; reset only blocks the write.
  always_ff @(posedge Clk) begin
    if (Rst && wr_acc) mem_q[wr_ptr_q] <= dataIn;
  end

  assign Count        = cnt_q;
  assign EMPTY        = (cnt_q == '0);
  assign FULL         = (cnt_q == DEPTH_C);
  assign ALMOST_EMPTY = (int'(cnt_q) <= AE_LEVEL);
  assign ALMOST_FULL  = (int'(cnt_q) >= AF_LEVEL);
  assign OVERFLOW     = ovf_q;
  assign UNDERFLOW    = unf_q;

  generate
    if (FWFT == 0) begin : g_std
      logic [DATA_WIDTH-1:0] dout_q, dout_d;
      logic                  vld_q, vld_d;

      // dataOut holds its last value between accepted reads; VALID is a
      // one-cycle pulse following each accepted read.
      always_comb begin
        dout_d = dout_q;
        vld_d  = rd_acc;
        if (rd_acc) dout_d = head_data;
      end

      always_ff @(posedge Clk) begin
        if (!Rst) begin
          dout_q <= '0;
          vld_q  <= 1'b0;
        end else begin
          dout_q <= dout_d;
          vld_q  <= vld_d;
        end
      end

      assign dataOut = dout_q;
      assign VALID   = vld_q;
    end else begin : g_fwft
      // Head word is always on the bus; RD acts as a pop acknowledge.
      assign dataOut = head_data;
      assign VALID   = (cnt_q != '0);
    end
  endgenerate

endmodule

// File: tb/tb_fifo_sync_param.sv
module tb_fifo_sync_param;

  localparam int DW = 32;
  localparam int DEPTH = 8;
  localparam int AF = DEPTH - 2;
  localparam int AE = 2;
  localparam int CW = $clog2(DEPTH) + 1;

  logic          Clk = 1'b0;
  logic          Rst, EN, WR, RD, CLR_ERR;
  logic [DW-1:0] dataIn;

  logic [DW-1:0] s_dout, f_dout;
  logic          s_vld, s_empty, s_full, s_ae, s_af, s_ovf, s_unf;
  logic          f_vld, f_empty, f_full, f_ae, f_af, f_ovf, f_unf;
  logic [CW-1:0] s_cnt, f_cnt;

  always #5 Clk = ~Clk;

  fifo_sync_param #(.DATA_WIDTH(DW), .DEPTH(DEPTH), .FWFT(0)) u_std (
    .Clk(Clk), .Rst(Rst), .EN(EN), .WR(WR), .dataIn(dataIn), .RD(RD),
    .CLR_ERR(CLR_ERR), .dataOut(s_dout), .VALID(s_vld), .EMPTY(s_empty),
    .FULL(s_full), .ALMOST_EMPTY(s_ae), .ALMOST_FULL(s_af), .Count(s_cnt),
    .OVERFLOW(s_ovf), .UNDERFLOW(s_unf)
  );

  fifo_sync_param #(.DATA_WIDTH(DW), .DEPTH(DEPTH), .FWFT(1)) u_fwft (
    .Clk(Clk), .Rst(Rst), .EN(EN), .WR(WR), .dataIn(dataIn), .RD(RD),
    .CLR_ERR(CLR_ERR), .dataOut(f_dout), .VALID(f_vld), .EMPTY(f_empty),
    .FULL(f_full), .ALMOST_EMPTY(f_ae), .ALMOST_FULL(f_af), .Count(f_cnt),
    .OVERFLOW(f_ovf), .UNDERFLOW(f_unf)
  );

  int vectors = 0;
  int miscompares = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Reference model: a queue of stored words plus the standard-mode output
  // register and the two sticky flags.
  logic [DW-1:0] m_q[$];
  logic [DW-1:0] m_dout;
  logic          m_vld, m_ovf, m_unf;

  task automatic model_step(input logic rst, en, wr, rd, clr, input logic [DW-1:0] din);
    bit rd_ok, wr_ok;
    if (!rst) begin
      m_q.delete();
      m_dout = '0; m_vld = 0; m_ovf = 0; m_unf = 0;
    end else if (!en) begin
      m_vld = 0;
    end else begin
      rd_ok = rd && (m_q.size() != 0);
      wr_ok = wr && ((m_q.size() != DEPTH) || rd_ok);
      m_ovf = (wr && !wr_ok) || (m_ovf && !clr);
      m_unf = (rd && !rd_ok) || (m_unf && !clr);
      if (rd_ok) m_dout = m_q.pop_front();
      m_vld = rd_ok;
      if (wr_ok) m_q.push_back(din);
    end
  endtask

  task automatic model_check();
    int n = m_q.size();
    chk("std_count", 64'(s_cnt), 64'(n));
    chk("std_empty", 64'(s_empty), 64'(n == 0));
    chk("std_full", 64'(s_full), 64'(n == DEPTH));
    chk("std_ae", 64'(s_ae), 64'(n <= AE));
    chk("std_af", 64'(s_af), 64'(n >= AF));
    chk("std_dout", 64'(s_dout), 64'(m_dout));
    chk("std_valid", 64'(s_vld), 64'(m_vld));
    chk("std_ovf", 64'(s_ovf), 64'(m_ovf));
    chk("std_unf", 64'(s_unf), 64'(m_unf));
    chk("fwft_count", 64'(f_cnt), 64'(n));
    chk("fwft_empty", 64'(f_empty), 64'(n == 0));
    chk("fwft_full", 64'(f_full), 64'(n == DEPTH));
    chk("fwft_ae", 64'(f_ae), 64'(n <= AE));
    chk("fwft_af", 64'(f_af), 64'(n >= AF));
    chk("fwft_valid", 64'(f_vld), 64'(n != 0));
    if (n != 0) chk("fwft_dout", 64'(f_dout), 64'(m_q[0]));
    chk("fwft_ovf", 64'(f_ovf), 64'(m_ovf));
    chk("fwft_unf", 64'(f_unf), 64'(m_unf));
  endtask

  // Drive one cycle of inputs, let the edge happen, update the model, compare.
  task automatic step(input logic rst, en, wr, rd, clr, input logic [DW-1:0] din);
    Rst = rst; EN = en; WR = wr; RD = rd; CLR_ERR = clr; dataIn = din;
    @(posedge Clk);
    #1;
    model_step(rst, en, wr, rd, clr, din);
    model_check();
  endtask

  typedef struct {
    logic          rst, en, wr, rd, clr;
    logic [DW-1:0] din;
    int            cnt;
    logic          vld;
    logic [DW-1:0] dout;
    logic          ovf, unf;
  } vec_t;

  vec_t tbl[$];

  function automatic void add(input logic rst, en, wr, rd, clr, input logic [DW-1:0] din,
                              input int cnt, input logic vld, input logic [DW-1:0] dout,
                              input logic ovf, unf);
    vec_t v;
    v.rst = rst; v.en = en; v.wr = wr; v.rd = rd; v.clr = clr; v.din = din;
    v.cnt = cnt; v.vld = vld; v.dout = dout; v.ovf = ovf; v.unf = unf;
    tbl.push_back(v);
  endfunction

  logic [DW-1:0] got[$];
  logic [CW-1:0] hold_cnt;
  logic [DW-1:0] hold_dout;
  int            wbias;

  initial begin
    Rst = 0; EN = 0; WR = 0; RD = 0; CLR_ERR = 0; dataIn = '0;
    m_dout = '0; m_vld = 0; m_ovf = 0; m_unf = 0;

    // ---------------- table of expected standard-mode behaviour ----------------
    add(0,1,0,0,0,32'h0,    0,0,32'h0,0,0);
    for (int i = 0; i < 8; i++) add(1,1,1,0,0,32'hA0+i, i+1,0,32'h0,0,0);
    add(1,1,1,0,0,32'hEE,   8,0,32'h0,1,0);
    add(1,1,0,0,1,32'h0,    8,0,32'h0,0,0);
    for (int i = 0; i < 8; i++) add(1,1,0,1,0,32'h0, 7-i,1,32'hA0+i,0,0);
    add(1,1,0,1,0,32'h0,    0,0,32'hA7,0,1);
    add(1,1,0,0,1,32'h0,    0,0,32'hA7,0,0);
    for (int i = 0; i < 8; i++) add(1,1,1,0,0,32'hA0+i, i+1,0,32'hA7,0,0);
    add(1,1,1,1,0,32'hB0,   8,1,32'hA0,0,0);
    for (int i = 0; i < 7; i++) add(1,1,0,1,0,32'h0, 7-i,1,32'hA1+i,0,0);
    add(1,1,0,1,0,32'h0,    0,1,32'hB0,0,0);
    add(1,1,1,1,0,32'h55,   1,0,32'hB0,0,1);
    add(1,1,0,0,1,32'h0,    1,0,32'hB0,0,0);
    for (int i = 0; i < 7; i++) add(1,1,1,0,0,32'hC1+i, i+2,0,32'hB0,0,0);
    add(1,1,1,0,1,32'hEE,   8,0,32'hB0,1,0);
    add(1,1,0,1,0,32'h0,    7,1,32'h55,1,0);
    add(1,1,0,1,0,32'h0,    6,1,32'hC1,1,0);
    add(1,1,0,1,0,32'h0,    5,1,32'hC2,1,0);
    add(0,1,1,1,1,32'h77,   0,0,32'h0,0,0);
    add(1,1,0,0,0,32'h0,    0,0,32'h0,0,0);
    add(1,0,1,1,0,32'h11,   0,0,32'h0,0,0);

    foreach (tbl[k]) begin
      step(tbl[k].rst, tbl[k].en, tbl[k].wr, tbl[k].rd, tbl[k].clr, tbl[k].din);
      chk($sformatf("tbl%0d_count", k), 64'(s_cnt), 64'(tbl[k].cnt));
      chk($sformatf("tbl%0d_empty", k), 64'(s_empty), 64'(tbl[k].cnt == 0));
      chk($sformatf("tbl%0d_full", k), 64'(s_full), 64'(tbl[k].cnt == DEPTH));
      chk($sformatf("tbl%0d_af", k), 64'(s_af), 64'(tbl[k].cnt >= AF));
      chk($sformatf("tbl%0d_ae", k), 64'(s_ae), 64'(tbl[k].cnt <= AE));
      chk($sformatf("tbl%0d_valid", k), 64'(s_vld), 64'(tbl[k].vld));
      chk($sformatf("tbl%0d_dout", k), 64'(s_dout), 64'(tbl[k].dout));
      chk($sformatf("tbl%0d_ovf", k), 64'(s_ovf), 64'(tbl[k].ovf));
      chk($sformatf("tbl%0d_unf", k), 64'(s_unf), 64'(tbl[k].unf));
    end

    // ---------------- wrap-around with an enable gap ----------------
    step(0,1,0,0,0,32'h0);
    got.delete();
    for (int i = 0; i < 3; i++) step(1,1,1,0,0,32'(i));
    for (int i = 3; i < 20; i++) begin
      if (i == 10) begin
        hold_cnt = s_cnt; hold_dout = s_dout;
        for (int g = 0; g < 3; g++) begin
          step(1,0,1,1,1,32'hDEAD);
          chk("gap_count", 64'(s_cnt), 64'(hold_cnt));
          chk("gap_dout", 64'(s_dout), 64'(hold_dout));
        end
      end
      step(1,1,1,1,0,32'(i));
      if (s_vld) got.push_back(s_dout);
    end
    for (int i = 0; i < 3; i++) begin
      step(1,1,0,1,0,32'h0);
      if (s_vld) got.push_back(s_dout);
    end
    chk("wrap_len", 64'(got.size()), 64'd20);
    for (int i = 0; i < got.size() && i < 20; i++)
      chk($sformatf("wrap_order%0d", i), 64'(got[i]), 64'(i));

    // ---------------- randomized against the model ----------------
    wbias = 50;
    for (int c = 0; c < 3000; c++) begin
      if (c % 64 == 0) wbias = $urandom_range(15, 85);
      step($urandom_range(0, 199) != 0,
           $urandom_range(0, 9) != 0,
           $urandom_range(0, 99) < wbias,
           $urandom_range(0, 99) >= wbias,
           $urandom_range(0, 19) == 0,
           $urandom);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
